// File: rtl/cordicp_result_fifo_if.sv
// cordicp_result_fifo_if: result-path handshake, occupancy and overflow signals of the result FIFO.
interface cordicp_result_fifo_if #(parameter int ADDR_W = 2, parameter int DROP_W = 8);
  logic [63:0] in_y;
  logic in_valid;
  logic [31:0] out_data;
  logic out_sat;
  logic out_valid;
  logic out_ready;
  logic [ADDR_W:0] count;
  logic afull;
  logic ovf;
  logic ovf_clr;
  logic [DROP_W-1:0] drop_cnt;
  modport master(output in_y, in_valid, out_ready, ovf_clr,
                 input out_data, out_sat, out_valid, count, afull, ovf, drop_cnt);
  modport slave(input in_y, in_valid, out_ready, ovf_clr,
                output out_data, out_sat, out_valid, count, afull, ovf, drop_cnt);
endinterface

// File: rtl/cordicp_result_fifo.sv
// cordicp_result_fifo: 32.32 -> saturated 16.16 result FIFO with first-word fall-through output.
// Define CORDICP_RESULT_ROUND_EN for round-half-up instead of truncation.
module cordicp_result_fifo #(
  parameter int ADDR_W = 2,
  parameter int DROP_W = 8
) (
  input logic clk,
  input logic rst,
  cordicp_result_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(2**ADDR_W);
  logic [32:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [ADDR_W:0] cnt, cnt_nxt;
  logic [31:0] data, out_data;
  logic sat, out_sat, ovf;
  logic [32:0] head;
  logic [DROP_W-1:0] drop_cnt;
  logic full, pop, push, drop;
  logic unused_lsb;
  assign unused_lsb = ^bus.in_y[15:0];
`ifdef CORDICP_RESULT_ROUND_EN
  logic [32:0] rsum;
  assign rsum = {1'b0, bus.in_y[47:16]} + 33'(bus.in_y[15]);
  assign sat = |bus.in_y[63:48] | rsum[32];
  assign data = sat ? '1 : rsum[31:0];
`else
  assign sat = |bus.in_y[63:48];
  assign data = sat ? '1 : bus.in_y[47:16];
`endif
  assign full = cnt == FULL;
  assign pop = (cnt != '0) & bus.out_ready;
  assign push = bus.in_valid & (~full | pop);
  assign drop = bus.in_valid & full & ~pop;
  assign rd_nxt = rd_ptr + ADDR_W'(pop);
  assign cnt_nxt = cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  // The next head is the incoming word only when it lands in the slot the read pointer moves to.
  assign head = (push && wr_ptr == rd_nxt) ? {sat, data} : mem[rd_nxt];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {sat, data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      out_data <= '0;
      out_sat <= 1'b0;
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      cnt <= cnt_nxt;
      if (cnt_nxt != '0) {out_sat, out_data} <= head;
      ovf <= drop | (ovf & ~bus.ovf_clr);
      if (drop) drop_cnt <= bus.ovf_clr ? DROP_W'(1) : (&drop_cnt ? drop_cnt : drop_cnt + 1'b1);
      else if (bus.ovf_clr) drop_cnt <= '0;
    end
  end
  assign bus.out_data = out_data;
  assign bus.out_sat = out_sat;
  assign bus.out_valid = cnt != '0;
  assign bus.count = cnt;
  assign bus.afull = cnt >= FULL - 1'b1;
  assign bus.ovf = ovf;
  assign bus.drop_cnt = drop_cnt;
endmodule
